// File: rtl/hwpe_ctrl_job_queue.sv
// rtl/hwpe_ctrl_job_queue.sv - HWPE offload controller with N-slot job FIFO, lock, cancel and event routing
module hwpe_ctrl_job_queue #(
  parameter int unsigned N_CORES      = 8,
  parameter int unsigned N_CONTEXT    = 4,
  parameter int unsigned N_EVT        = 2,
  parameter int unsigned ID_WIDTH     = 16,
  parameter int unsigned CLEAR_CYCLES = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_req_i,
  output logic                           cfg_gnt_o,
  input  logic [31:0]                    cfg_add_i,
  input  logic                           cfg_wen_i,
  input  logic [31:0]                    cfg_data_i,
  input  logic [ID_WIDTH-1:0]            cfg_id_i,
  output logic [31:0]                    cfg_r_data_o,
  output logic                           cfg_r_valid_o,
  output logic [ID_WIDTH-1:0]            cfg_r_id_o,
  output logic                           clear_o,
  output logic [$clog2(N_CONTEXT)-1:0]   wr_ctx_o,
  output logic [$clog2(N_CONTEXT)-1:0]   run_ctx_o,
  output logic                           start_o,
  output logic                           busy_o,
  input  logic                           done_i,
  input  logic [N_EVT-1:0]               evt_i,
  output logic [N_CORES*(N_EVT+1)-1:0]   evt_o,
  output logic                           err_o
);

  localparam int unsigned CORE_W = $clog2(N_CORES);
  localparam int unsigned CTX_W  = $clog2(N_CONTEXT);
  localparam int unsigned CNT_W  = CTX_W + 1;
  localparam int unsigned CLR_W  = $clog2(CLEAR_CYCLES + 1);
  localparam int unsigned EVW    = N_EVT + 1;

  typedef enum logic [1:0] {IDLE, STARTING, RUNNING} state_e;

  state_e                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        start_q, start_d;
  logic [CTX_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CTX_W-1:0]            run_ptr_q, run_ptr_d;
  logic [CNT_W-1:0]            pending_q, pending_d;
  logic                        lock_valid_q, lock_valid_d;
  logic [CORE_W-1:0]           lock_owner_q, lock_owner_d;
  logic [CORE_W-1:0]           owner_q [N_CONTEXT];
  logic [CORE_W-1:0]           owner_d [N_CONTEXT];
  logic [15:0]                 finished_q, finished_d;
  logic                        err_q, err_d;
  logic [N_CORES*EVW-1:0]      evt_q, evt_d;
  logic [CLR_W-1:0]            clr_cnt_q, clr_cnt_d;
  logic                        r_valid_q, r_valid_d;
  logic [31:0]                 r_data_q, r_data_d;
  logic [ID_WIDTH-1:0]         r_id_q, r_id_d;

  logic                        gnt, rd_req, wr_req, is_owner, full, push, pop, do_clear;
  logic [CORE_W-1:0]           core;
  logic [2:0]                  off;
  logic [N_EVT-1:0]            evt_fwd;
  logic                        unused_bits;

  assign unused_bits = ^{cfg_add_i[31:5], cfg_add_i[1:0], cfg_data_i};

  assign clear_o   = (clr_cnt_q != '0);
  assign gnt       = cfg_req_i && !clear_o;
  assign rd_req    = gnt && cfg_wen_i;
  assign wr_req    = gnt && !cfg_wen_i;
  assign core      = cfg_id_i[CORE_W-1:0];
  assign off       = cfg_add_i[4:2];
  assign is_owner  = lock_valid_q && (lock_owner_q == core);
  assign full      = (pending_q == CNT_W'(N_CONTEXT));
  assign evt_fwd   = busy_q ? evt_i : '0;

  assign cfg_gnt_o     = !clear_o;
  assign cfg_r_data_o  = r_data_q;
  assign cfg_r_valid_o = r_valid_q;
  assign cfg_r_id_o    = r_id_q;
  assign wr_ctx_o      = wr_ptr_q;
  assign run_ctx_o     = run_ptr_q;
  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign evt_o         = evt_q;
  assign err_o         = err_q;

  // Register access, lock handling, dispatch FSM, event routing and soft clear
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    start_d      = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    run_ptr_d    = run_ptr_q;
    pending_d    = pending_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    owner_d      = owner_q;
    finished_d   = finished_q;
    err_d        = err_q;
    evt_d        = '0;
    clr_cnt_d    = clr_cnt_q;
    r_valid_d    = gnt;
    r_id_d       = gnt ? cfg_id_i : '0;
    r_data_d     = '0;
    push         = 1'b0;
    pop          = 1'b0;
    do_clear     = 1'b0;

    if (rd_req) begin
      case (off)
        3'd1: begin
          if (is_owner) begin
            r_data_d = 32'(wr_ptr_q);
          end else if (!lock_valid_q && !full) begin
            r_data_d     = 32'(wr_ptr_q);
            lock_valid_d = 1'b1;
            lock_owner_d = core;
          end else begin
            r_data_d = 32'hFFFF_FFFF;
          end
        end
        3'd2:    r_data_d = 32'(finished_q);
        3'd3:    r_data_d = {8'b0, 8'(lock_owner_q), lock_valid_q, 3'b0, 12'(pending_q)};
        3'd4:    r_data_d = {busy_q, 31'(run_ptr_q)};
        default: r_data_d = '0;
      endcase
    end

    if (wr_req) begin
      case (off)
        3'd0: begin
          if (is_owner) push = 1'b1;
          else          err_d = 1'b1;
        end
        3'd5: do_clear = 1'b1;
        3'd6: begin
          if (is_owner) begin
            lock_valid_d = 1'b0;
            lock_owner_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        3'd7:    err_d = 1'b0;
        default: ;
      endcase
    end

    if (push) begin
      owner_d[wr_ptr_q] = lock_owner_q;
      wr_ptr_d          = wr_ptr_q + CTX_W'(1);
      lock_valid_d      = 1'b0;
      lock_owner_d      = '0;
    end

    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          state_d = STARTING;
          busy_d  = 1'b1;
        end
      end
      STARTING: begin
        start_d = 1'b1;
        state_d = RUNNING;
      end
      RUNNING: begin
        if (done_i) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          pop        = 1'b1;
          run_ptr_d  = run_ptr_q + CTX_W'(1);
          finished_d = finished_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = pending_q + CNT_W'(push) - CNT_W'(pop);

    for (int c = 0; c < N_CORES; c++) begin
      if (CORE_W'(c) == owner_q[run_ptr_q]) evt_d[c*EVW +: EVW] = {evt_fwd, pop};
    end

    if (do_clear)               clr_cnt_d = CLR_W'(CLEAR_CYCLES);
    else if (clr_cnt_q != '0)   clr_cnt_d = clr_cnt_q - CLR_W'(1);

    // Clear window holds everything except the bus response path at reset values
    if (do_clear || clear_o) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      start_d      = 1'b0;
      wr_ptr_d     = '0;
      run_ptr_d    = '0;
      pending_d    = '0;
      lock_valid_d = 1'b0;
      lock_owner_d = '0;
      for (int i = 0; i < N_CONTEXT; i++) owner_d[i] = '0;
      finished_d   = '0;
      err_d        = 1'b0;
      evt_d        = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      wr_ptr_q     <= '0;
      run_ptr_q    <= '0;
      pending_q    <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      for (int i = 0; i < N_CONTEXT; i++) owner_q[i] <= '0;
      finished_q   <= '0;
      err_q        <= 1'b0;
      evt_q        <= '0;
      clr_cnt_q    <= '0;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      r_id_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      wr_ptr_q     <= wr_ptr_d;
      run_ptr_q    <= run_ptr_d;
      pending_q    <= pending_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      owner_q      <= owner_d;
      finished_q   <= finished_d;
      err_q        <= err_d;
      evt_q        <= evt_d;
      clr_cnt_q    <= clr_cnt_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_id_q       <= r_id_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
// tb/tb_hwpe_ctrl_job_queue.sv - self-checking bench for hwpe_ctrl_job_queue
module tb_hwpe_ctrl_job_queue;

  localparam int NCORE = 8;
  localparam int NC    = 4;
  localparam int NE    = 2;
  localparam int IDW   = 16;
  localparam int CC    = 3;
  localparam int EVW   = NE + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b1;
  logic                  cfg_req_i = 1'b0;
  logic                  cfg_gnt_o;
  logic [31:0]           cfg_add_i = '0;
  logic                  cfg_wen_i = 1'b0;
  logic [31:0]           cfg_data_i = '0;
  logic [IDW-1:0]        cfg_id_i = '0;
  logic [31:0]           cfg_r_data_o;
  logic                  cfg_r_valid_o;
  logic [IDW-1:0]        cfg_r_id_o;
  logic                  clear_o;
  logic [1:0]            wr_ctx_o;
  logic [1:0]            run_ctx_o;
  logic                  start_o;
  logic                  busy_o;
  logic                  done_i = 1'b0;
  logic [NE-1:0]         evt_i = '0;
  logic [NCORE*EVW-1:0]  evt_o;
  logic                  err_o;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_job_queue #(
    .N_CORES(NCORE), .N_CONTEXT(NC), .N_EVT(NE), .ID_WIDTH(IDW), .CLEAR_CYCLES(CC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_add_i(cfg_add_i),
    .cfg_wen_i(cfg_wen_i), .cfg_data_i(cfg_data_i), .cfg_id_i(cfg_id_i),
    .cfg_r_data_o(cfg_r_data_o), .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_id_o(cfg_r_id_o),
    .clear_o(clear_o), .wr_ctx_o(wr_ctx_o), .run_ctx_o(run_ctx_o),
    .start_o(start_o), .busy_o(busy_o), .done_i(done_i), .evt_i(evt_i),
    .evt_o(evt_o), .err_o(err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One bus transaction; the response is checked on the edge that follows it
  task automatic bus(input logic wen, input logic [2:0] off, input int core, input logic dn,
                     output logic [31:0] rd);
    logic [IDW-1:0] id;
    id         = 16'hA500 | 16'(core);
    cfg_req_i  = 1'b1;
    cfg_wen_i  = wen;
    cfg_add_i  = {27'b0, off, 2'b00};
    cfg_data_i = $urandom;
    cfg_id_i   = id;
    done_i     = dn;
    step();
    cfg_req_i  = 1'b0;
    done_i     = 1'b0;
    chk("r_valid", cfg_r_valid_o, 1);
    chk("r_id", cfg_r_id_o, id);
    rd = cfg_r_data_o;
  endtask

  task automatic do_reset();
    rst_ni = 1'b1;
    #1;
    rst_ni = 1'b0;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_clear", clear_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_evt", evt_o, 0);
    chk("rst_rvalid", cfg_r_valid_o, 0);
    chk("rst_rdata", cfg_r_data_o, 0);
    chk("rst_wrctx", wr_ctx_o, 0);
    chk("rst_runctx", run_ctx_o, 0);
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  // Reference model: list of job owners awaiting completion, plus lock and slot counters
  int m_q[$];
  bit m_lock;
  int m_owner;
  int m_wr;
  int m_run;
  int m_fin;
  bit m_err;

  task automatic m_init();
    m_q.delete();
    m_lock = 0; m_owner = 0; m_wr = 0; m_run = 0; m_fin = 0; m_err = 0;
  endtask

  task automatic m_acquire(input int core);
    logic [31:0] exp, rd;
    if (m_lock && m_owner == core) exp = m_wr;
    else if (!m_lock && m_q.size() < NC) begin
      exp = m_wr; m_lock = 1; m_owner = core;
    end else exp = 32'hFFFF_FFFF;
    bus(1'b1, 3'd1, core, 1'b0, rd);
    chk("m_acquire", rd, exp);
    chk("m_err", err_o, m_err);
  endtask

  task automatic m_trigger(input int core);
    logic [31:0] rd;
    if (m_lock && m_owner == core) begin
      m_q.push_back(core); m_wr = (m_wr + 1) % NC; m_lock = 0;
    end else m_err = 1;
    bus(1'b0, 3'd0, core, 1'b0, rd);
    chk("m_trig_err", err_o, m_err);
    chk("m_wr_ctx", wr_ctx_o, m_wr);
  endtask

  task automatic m_cancel(input int core);
    logic [31:0] rd;
    if (m_lock && m_owner == core) m_lock = 0;
    else m_err = 1;
    bus(1'b0, 3'd6, core, 1'b0, rd);
    chk("m_cancel_err", err_o, m_err);
  endtask

  task automatic m_status(input int core);
    logic [31:0] rd;
    int exp;
    exp = (m_lock ? (m_owner * 65536 + 32768) : 0) + m_q.size();
    bus(1'b1, 3'd3, core, 1'b0, rd);
    chk("m_status", rd, exp);
  endtask

  task automatic m_finished(input int core);
    logic [31:0] rd;
    bus(1'b1, 3'd2, core, 1'b0, rd);
    chk("m_finished", rd, m_fin % 65536);
  endtask

  task automatic m_errclr(input int core);
    logic [31:0] rd;
    m_err = 0;
    bus(1'b0, 3'd7, core, 1'b0, rd);
    chk("m_errclr", err_o, 0);
  endtask

  // Let the engine pick up the oldest job, then complete it and check who is told
  task automatic m_complete();
    int k;
    int own;
    logic [NCORE*EVW-1:0] exp_evt;
    if (m_q.size() == 0) return;
    k = 0;
    while (busy_o !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("m_busy_wait", busy_o, 1);
    step();
    chk("m_run_ctx", run_ctx_o, m_run);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    own = m_q.pop_front();
    exp_evt = '0;
    exp_evt[own*EVW] = 1'b1;
    chk("m_evt_done", evt_o, exp_evt);
    chk("m_busy_low", busy_o, 0);
    m_fin++;
    m_run = (m_run + 1) % NC;
    step();
    chk("m_evt_pulse", evt_o, 0);
  endtask

  typedef struct {
    logic        wen;
    logic [2:0]  off;
    int          core;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [21];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int c, r;

    vt[0]  = '{1'b1, 3'd1, 1, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b1, 3'd1, 5, 32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 5, 32'h0000_0000, 1'b1};
    vt[3]  = '{1'b1, 3'd3, 5, 32'h0001_8000, 1'b1};
    vt[4]  = '{1'b0, 3'd7, 0, 32'h0000_0000, 1'b0};
    vt[5]  = '{1'b1, 3'd1, 1, 32'h0000_0000, 1'b0};
    vt[6]  = '{1'b0, 3'd0, 1, 32'h0000_0000, 1'b0};
    vt[7]  = '{1'b1, 3'd1, 3, 32'h0000_0001, 1'b0};
    vt[8]  = '{1'b0, 3'd6, 3, 32'h0000_0000, 1'b0};
    vt[9]  = '{1'b1, 3'd3, 3, 32'h0000_0001, 1'b0};
    vt[10] = '{1'b1, 3'd1, 3, 32'h0000_0001, 1'b0};
    vt[11] = '{1'b0, 3'd6, 2, 32'h0000_0000, 1'b1};
    vt[12] = '{1'b1, 3'd3, 2, 32'h0003_8001, 1'b1};
    vt[13] = '{1'b0, 3'd7, 2, 32'h0000_0000, 1'b0};
    vt[14] = '{1'b1, 3'd0, 4, 32'h0000_0000, 1'b0};
    vt[15] = '{1'b1, 3'd2, 4, 32'h0000_0000, 1'b0};
    vt[16] = '{1'b0, 3'd1, 4, 32'h0000_0000, 1'b0};
    vt[17] = '{1'b1, 3'd5, 4, 32'h0000_0000, 1'b0};
    vt[18] = '{1'b1, 3'd4, 4, 32'h8000_0000, 1'b0};
    vt[19] = '{1'b0, 3'd6, 3, 32'h0000_0000, 1'b0};
    vt[20] = '{1'b0, 3'd6, 3, 32'h0000_0000, 1'b1};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      bus(vt[i].wen, vt[i].off, vt[i].core, 1'b0, rd);
      if (vt[i].wen) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), err_o, vt[i].exp_err);
    end

    // Single job: start latency, event forwarding, done notification
    do_reset();
    bus(1'b1, 3'd1, 2, 1'b0, rd);
    chk("lat_acq", rd, 0);
    bus(1'b0, 3'd0, 2, 1'b0, rd);
    chk("lat_busy_T", busy_o, 0);
    chk("lat_start_T", start_o, 0);
    step();
    chk("lat_busy_T1", busy_o, 1);
    chk("lat_start_T1", start_o, 0);
    step();
    chk("lat_start_T2", start_o, 1);
    chk("lat_run_ctx", run_ctx_o, 0);
    evt_i = 2'b11;
    step();
    evt_i = 2'b00;
    chk("lat_start_once", start_o, 0);
    chk("lat_evt_fwd", evt_o, 24'h3 << 7);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("lat_evt_done", evt_o, 24'h1 << 6);
    chk("lat_busy_off", busy_o, 0);
    step();
    chk("lat_evt_pulse", evt_o, 0);
    bus(1'b1, 3'd2, 2, 1'b0, rd);
    chk("lat_finished", rd, 1);

    // Trigger coincident with done: count unchanged, one idle cycle before restart
    do_reset();
    bus(1'b1, 3'd1, 0, 1'b0, rd);
    bus(1'b0, 3'd0, 0, 1'b0, rd);
    step();
    step();
    chk("co_start", start_o, 1);
    bus(1'b1, 3'd1, 1, 1'b0, rd);
    chk("co_acq", rd, 1);
    bus(1'b0, 3'd0, 1, 1'b1, rd);
    chk("co_busy_D", busy_o, 0);
    chk("co_evt_D", evt_o, 24'h1);
    chk("co_run_ctx", run_ctx_o, 1);
    chk("co_wr_ctx", wr_ctx_o, 2);
    step();
    chk("co_busy_D1", busy_o, 1);
    chk("co_start_D1", start_o, 0);
    step();
    chk("co_start_D2", start_o, 1);
    bus(1'b1, 3'd3, 1, 1'b0, rd);
    chk("co_pending", rd, 1);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("co_evt_2", evt_o, 24'h1 << 3);
    bus(1'b1, 3'd2, 1, 1'b0, rd);
    chk("co_finished", rd, 2);

    // Soft clear while a job runs
    do_reset();
    bus(1'b1, 3'd1, 0, 1'b0, rd);
    bus(1'b0, 3'd0, 0, 1'b0, rd);
    step();
    step();
    step();
    chk("sc_busy_pre", busy_o, 1);
    bus(1'b0, 3'd5, 0, 1'b0, rd);
    for (int i = 0; i < CC; i++) begin
      chk($sformatf("sc_clear%0d", i), clear_o, 1);
      chk($sformatf("sc_gnt%0d", i), cfg_gnt_o, 0);
      chk($sformatf("sc_busy%0d", i), busy_o, 0);
      cfg_req_i = 1'b1; cfg_wen_i = 1'b1; cfg_add_i = 32'h4; cfg_id_i = 16'h0001;
      done_i = 1'b1;
      step();
      cfg_req_i = 1'b0;
      chk($sformatf("sc_rvalid%0d", i), cfg_r_valid_o, 0);
      chk($sformatf("sc_evt%0d", i), evt_o, 0);
    end
    done_i = 1'b0;
    chk("sc_clear_end", clear_o, 0);
    chk("sc_gnt_end", cfg_gnt_o, 1);
    step();
    step();
    chk("sc_busy_after", busy_o, 0);
    bus(1'b1, 3'd2, 1, 1'b0, rd);
    chk("sc_finished", rd, 0);
    bus(1'b1, 3'd1, 1, 1'b0, rd);
    chk("sc_acq", rd, 0);
    chk("sc_err", err_o, 0);

    // Model-checked: fill the queue, refuse the fifth acquire, drain in order
    do_reset();
    m_init();
    for (int k = 0; k < NC; k++) begin
      m_acquire(k);
      m_trigger(k);
    end
    m_acquire(4);
    m_status(4);
    for (int k = 0; k < NC; k++) m_complete();
    chk("full_run_wrap", run_ctx_o, 0);
    m_finished(0);

    // Model-checked random traffic
    for (int it = 0; it < 400; it++) begin
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NCORE-1)) : int'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 30)      m_acquire(c);
      else if (r < 55) m_trigger(c);
      else if (r < 63) m_cancel(c);
      else if (r < 73) m_status(c);
      else if (r < 78) m_finished(c);
      else if (r < 83) m_errclr(c);
      else             m_complete();
    end
    while (m_q.size() > 0) m_complete();
    m_finished(0);
    m_status(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
